ripple_sum_deskew_checker_8bit: RTL

- Receive-side companion to the clocked 8-bit ripple-carry adder: one clocked full-adder stage per bit, carry advancing one stage per clock.
- Sum bits leave the adder skewed: bit i is valid BASE_LAT+i cycles after the operands are issued.
- This block re-aligns the skewed sum/cout into one word per operand set and computes the expected result from a delayed copy of the operands.
- It flags mismatches and keeps a saturating error count; it sits between the adder outputs and the testbench/scoreboard.

---
 rtl/ripple_sum_deskew_checker_8bit.sv | 118 +++++++++++
 1 files changed

// File: rtl/ripple_sum_deskew_checker_8bit.sv
// Re-aligns the bit-skewed sum/cout of a clocked ripple-carry adder into one word per
// operand set, checks it against a delayed reference sum and counts mismatches.
module ripple_sum_deskew_checker_8bit #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned BASE_LAT = 1,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [WIDTH-1:0] exp_sum,
    output logic             exp_cout,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic             sticky_err
);

    localparam int unsigned DEPTH = BASE_LAT + WIDTH;
    localparam int unsigned OPW   = 2 * WIDTH + 1;
    localparam int unsigned SUMW  = WIDTH + 1;

    // vld_pipe[k] is in_valid as issued k cycles ago; out_valid is the final stage
    logic [DEPTH-1:1] vld_pipe;
    logic [OPW-1:0]   op_pipe [1:DEPTH-1];

    // row[s] holds sum bits [s:0] of one operand set once bit s has been sampled
    logic [WIDTH-1:0] row     [0:WIDTH-2];
    logic [WIDTH-1:0] row_nxt [0:WIDTH-2];

    logic [WIDTH-1:0] word_nxt;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             cin_d;
    logic [SUMW-1:0]  exp_full;
    logic             cap_out;
    logic             mismatch_nxt;

    always_comb begin
        row_nxt[0]    = '0;
        row_nxt[0][0] = sum[0];
        for (int s = 1; s < WIDTH - 1; s++) begin
            row_nxt[s]    = row[s-1];
            row_nxt[s][s] = sum[s];
        end
    end

    for (genvar s = 0; s < WIDTH - 1; s++) begin : g_row
        always_ff @(posedge clk) begin
            if (rst) begin
                row[s] <= '0;
            end else if (vld_pipe[BASE_LAT+s]) begin
                row[s] <= row_nxt[s];
            end
        end
    end

    // Output word: the top bit and cout are sampled straight into the output register
    always_comb begin
        word_nxt            = row[WIDTH-2];
        word_nxt[WIDTH-1]   = sum[WIDTH-1];
        {a_d, b_d, cin_d}   = op_pipe[DEPTH-1];
        exp_full            = SUMW'(a_d) + SUMW'(b_d) + SUMW'(cin_d);
        cap_out             = vld_pipe[DEPTH-1];
        mismatch_nxt        = cap_out && ({cout, word_nxt} != exp_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            for (int k = 1; k < DEPTH; k++) begin
                op_pipe[k] <= '0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            exp_sum   <= '0;
            exp_cout  <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[DEPTH-2:1], in_valid};
            op_pipe[1] <= {in_a, in_b, in_cin};
            for (int k = 2; k < DEPTH; k++) begin
                op_pipe[k] <= op_pipe[k-1];
            end
            out_valid <= cap_out;
            mismatch  <= mismatch_nxt;
            if (cap_out) begin
                out_sum  <= word_nxt;
                out_cout <= cout;
                exp_sum  <= exp_full[WIDTH-1:0];
                exp_cout <= exp_full[WIDTH];
            end
        end
    end

    // Saturating error count; clear wins over a coincident mismatch
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err_count  <= '0;
            sticky_err <= 1'b0;
        end else if (mismatch) begin
            sticky_err <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule
